// File: rtl/node_cpu_csr_slave.sv
// Wishbone CSR slave for the node CPU cluster: per-core reset, program RAM upload window
// and a byte-wide debug FIFO fed by the cores.
module node_cpu_csr_slave #(
  parameter int unsigned g_num_cores      = 2,
  parameter int unsigned g_ram_addr_width = 14,
  parameter int unsigned g_fifo_depth     = 16
) (
  input  logic                        clk_sys_i,
  input  logic                        rst_i,
  input  logic [2:0]                  wb_adr_i,
  input  logic [31:0]                 wb_dat_i,
  output logic [31:0]                 wb_dat_o,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  output logic                        wb_ack_o,
  output logic [g_num_cores-1:0]      core_rst_o,
  output logic [2:0]                  core_sel_o,
  output logic [g_ram_addr_width-1:0] ram_addr_o,
  output logic [31:0]                 ram_data_o,
  output logic                        ram_we_o,
  output logic                        ram_re_o,
  input  logic [31:0]                 ram_data_i,
  input  logic                        dbg_valid_i,
  input  logic [7:0]                  dbg_data_i
);

  localparam int unsigned PtrW = $clog2(g_fifo_depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRamWait = 2'd1;
  localparam logic [1:0] StRamCap  = 2'd2;
  localparam logic [1:0] StAck     = 2'd3;

  localparam logic [2:0] AdrReset  = 3'd0;
  localparam logic [2:0] AdrSel    = 3'd1;
  localparam logic [2:0] AdrUaddr  = 3'd2;
  localparam logic [2:0] AdrUdata  = 3'd3;
  localparam logic [2:0] AdrStatus = 3'd4;
  localparam logic [2:0] AdrData   = 3'd5;

  logic [1:0]                  state_q, state_d;
  logic [g_num_cores-1:0]      core_rst_q, core_rst_d;
  logic [2:0]                  core_sel_q, core_sel_d;
  logic [g_ram_addr_width-1:0] uaddr_q, uaddr_d;
  logic [31:0]                 wb_dat_q, wb_dat_d;
  logic                        ram_we_q, ram_we_d;
  logic                        ram_re_q, ram_re_d;
  logic [g_ram_addr_width-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]                 ram_data_q, ram_data_d;
  logic                        ovf_q, ovf_d;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             cnt_q;
  logic [7:0]                  fifo_mem [g_fifo_depth];

  logic        access, fifo_empty, fifo_full, push, pop, ovf_clr;
  logic [31:0] status, rdata;

  assign access     = (state_q == StIdle) && wb_cyc_i && wb_stb_i;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(g_fifo_depth));
  // Pop is decided on the same edge that samples the head, so a push in that cycle
  // into an empty FIFO is kept rather than popped unread.
  assign pop        = access && !wb_we_i && (wb_adr_i == AdrData) && !fifo_empty;
  assign push       = dbg_valid_i && (!fifo_full || pop);
  assign status     = {16'b0, 8'(cnt_q), 5'b0, ovf_q, fifo_full, !fifo_empty};

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      AdrReset:  rdata = 32'(core_rst_q);
      AdrSel:    rdata = {29'b0, core_sel_q};
      AdrUaddr:  rdata = 32'(uaddr_q);
      AdrStatus: rdata = status;
      AdrData:   rdata = fifo_empty ? 32'b0 : {23'b0, 1'b1, fifo_mem[rd_ptr_q]};
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    core_sel_d = core_sel_q;
    uaddr_d    = uaddr_q;
    wb_dat_d   = wb_dat_q;
    ram_we_d   = 1'b0;
    ram_re_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ovf_clr    = 1'b0;
    case (state_q)
      StIdle: begin
        if (access) begin
          if (wb_adr_i == AdrUdata) begin
            ram_addr_d = uaddr_q;
            uaddr_d    = uaddr_q + g_ram_addr_width'(1);
            if (wb_we_i) begin
              ram_we_d   = 1'b1;
              ram_data_d = wb_dat_i;
              wb_dat_d   = rdata;
              state_d    = StAck;
            end else begin
              ram_re_d = 1'b1;
              state_d  = StRamWait;
            end
          end else begin
            wb_dat_d = rdata;
            state_d  = StAck;
            if (wb_we_i) begin
              case (wb_adr_i)
                AdrReset:  core_rst_d = wb_dat_i[g_num_cores-1:0];
                AdrSel:    core_sel_d = wb_dat_i[2:0];
                AdrUaddr:  uaddr_d    = wb_dat_i[g_ram_addr_width-1:0];
                AdrStatus: ovf_clr    = wb_dat_i[2];
                default:   ;
              endcase
            end
          end
        end
      end
      StRamWait: state_d = StRamCap;
      StRamCap: begin
        wb_dat_d = ram_data_i;
        state_d  = StAck;
      end
      default: state_d = StIdle;
    endcase
    // A drop in the same cycle as the clear is a fresh overflow and must stay visible.
    ovf_d = (ovf_q && !ovf_clr) || (dbg_valid_i && fifo_full && !pop);
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      core_rst_q <= '1;
      core_sel_q <= '0;
      uaddr_q    <= '0;
      wb_dat_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      core_sel_q <= core_sel_d;
      uaddr_q    <= uaddr_d;
      wb_dat_q   <= wb_dat_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ovf_q      <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (push) fifo_mem[wr_ptr_q] <= dbg_data_i;
  end

  assign wb_dat_o   = wb_dat_q;
  assign wb_ack_o   = (state_q == StAck);
  assign core_rst_o = core_rst_q;
  assign core_sel_o = core_sel_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;
  assign ram_we_o   = ram_we_q;
  assign ram_re_o   = ram_re_q;

endmodule

// File: tb/tb_node_cpu_csr_slave.sv
// Self-checking bench for node_cpu_csr_slave: register table, directed RAM/FIFO/reset
// sequences and a randomized FIFO run against a queue-based reference model.
module tb_node_cpu_csr_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat_w, wb_dat_r;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [1:0]  core_rst;
  logic [2:0]  core_sel;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
  logic        dbg_valid;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  node_cpu_csr_slave #(
    .g_num_cores      (2),
    .g_ram_addr_width (14),
    .g_fifo_depth     (16)
  ) dut (
    .clk_sys_i   (clk),
    .rst_i       (rst),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_dat_o    (wb_dat_r),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_we_i     (wb_we),
    .wb_ack_o    (wb_ack),
    .core_rst_o  (core_rst),
    .core_sel_o  (core_sel),
    .ram_addr_o  (ram_addr),
    .ram_data_o  (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_re_o    (ram_re),
    .ram_data_i  (ram_rdata),
    .dbg_valid_i (dbg_valid),
    .dbg_data_i  (dbg_data)
  );

  // Program RAM model: one-cycle read latency.
  bit [31:0] ram_mem [0:16383];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  int          re_cnt = 0;
  logic [13:0] log_addr [$];
  logic [31:0] log_data [$];
  always @(negedge clk) begin
    if (ram_re) re_cnt++;
    if (ram_we) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called and returns at #1 after a rising edge; the FSM is back in IDLE on return.
  task automatic bus(input logic [2:0] adr, input logic we, input logic [31:0] wdata,
                     input bit drop_early, input bit push_too, input logic [7:0] push_byte,
                     output logic [31:0] rdata, output int lat);
    bit got;
    got = 1'b0;
    rdata = '0;
    lat = 0;
    wb_adr = adr; wb_we = we; wb_dat_w = wdata; wb_cyc = 1'b1; wb_stb = 1'b1;
    if (push_too) begin
      dbg_valid = 1'b1;
      dbg_data  = push_byte;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      dbg_valid = 1'b0;
      if (drop_early) begin
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
      end
      if (wb_ack) begin
        got = 1'b1;
        rdata = wb_dat_r;
      end
    end
    if (!got) lat = 99;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [2:0] adr, output logic [31:0] data, output int lat);
    bus(adr, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, data, lat);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    int l;
    rd(adr, d, l);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] data);
    logic [31:0] d;
    int l;
    bus(adr, 1'b1, data, 1'b0, 1'b0, 8'h0, d, l);
    chk("wr_ack_latency", 32'(l), 32'd1);
  endtask

  task automatic push_seq(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      dbg_valid = 1'b1;
      dbg_data  = first + 8'(i);
      @(posedge clk); #1;
    end
    dbg_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  adr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [1:0]  exp_rst;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] d, wd, exp_d;
  int          lat, base, acks;
  int unsigned r, k;
  logic        v;
  logic [7:0]  mq [$];
  bit          movf;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 32'h0,        32'h3,   2'b11, 3'd0};
    tbl[1]  = '{3'd0, 1'b1, 32'h1,        32'h0,   2'b01, 3'd0};
    tbl[2]  = '{3'd0, 1'b0, 32'h0,        32'h1,   2'b01, 3'd0};
    tbl[3]  = '{3'd0, 1'b1, 32'hFFFFFFFE, 32'h0,   2'b10, 3'd0};
    tbl[4]  = '{3'd0, 1'b0, 32'h0,        32'h2,   2'b10, 3'd0};
    tbl[5]  = '{3'd1, 1'b1, 32'h5,        32'h0,   2'b10, 3'd5};
    tbl[6]  = '{3'd1, 1'b0, 32'h0,        32'h5,   2'b10, 3'd5};
    tbl[7]  = '{3'd1, 1'b1, 32'hFFFFFFFA, 32'h0,   2'b10, 3'd2};
    tbl[8]  = '{3'd2, 1'b0, 32'h0,        32'h0,   2'b10, 3'd2};
    tbl[9]  = '{3'd2, 1'b1, 32'hFFFFC123, 32'h0,   2'b10, 3'd2};
    tbl[10] = '{3'd2, 1'b0, 32'h0,        32'h123, 2'b10, 3'd2};
    tbl[11] = '{3'd6, 1'b1, 32'hFFFFFFFF, 32'h0,   2'b10, 3'd2};
    tbl[12] = '{3'd6, 1'b0, 32'h0,        32'h0,   2'b10, 3'd2};
    tbl[13] = '{3'd7, 1'b0, 32'h0,        32'h0,   2'b10, 3'd2};
    tbl[14] = '{3'd4, 1'b0, 32'h0,        32'h0,   2'b10, 3'd2};
    tbl[15] = '{3'd5, 1'b0, 32'h0,        32'h0,   2'b10, 3'd2};

    wb_adr = '0; wb_dat_w = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    dbg_valid = 1'b0; dbg_data = '0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'h3);
    chk("rst_core_sel", 32'(core_sel), 32'h0);
    chk("rst_wb_dat", wb_dat_r, 32'h0);
    chk("rst_ack_we_re", {29'b0, wb_ack, ram_we, ram_re}, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].adr, tbl[i].we, tbl[i].wdata, 1'b0, 1'b0, 8'h0, d, lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
      chk($sformatf("tbl%0d_ack_low_after", i), 32'(wb_ack), 32'd0);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
      chk($sformatf("tbl%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].exp_rst));
      chk($sformatf("tbl%0d_core_sel", i), 32'(core_sel), 32'(tbl[i].exp_sel));
    end
    chk("tbl_no_ram_we", 32'(log_addr.size()), 32'd0);

    // Upload with address wrap.
    base = log_addr.size();
    wr(3'd2, 32'h3FFF);
    wr(3'd3, 32'hA5A5A5A5);
    wr(3'd3, 32'h12345678);
    chk("upl_we_count", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      chk("upl_addr0", 32'(log_addr[base]), 32'h3FFF);
      chk("upl_data0", log_data[base], 32'hA5A5A5A5);
      chk("upl_addr1", 32'(log_addr[base+1]), 32'h0);
      chk("upl_data1", log_data[base+1], 32'h12345678);
    end
    rd_chk("upl_uaddr_wrapped", 3'd2, 32'h1);

    // RAM read path through the window.
    wr(3'd2, 32'h10);
    wr(3'd3, 32'hDEADBEEF);
    wr(3'd2, 32'h10);
    base = re_cnt;
    rd(3'd3, d, lat);
    chk("udata_rd_data", d, 32'hDEADBEEF);
    chk("udata_rd_latency", 32'(lat), 32'd3);
    chk("udata_rd_re_count", 32'(re_cnt - base), 32'd1);
    rd_chk("udata_rd_uaddr_inc", 3'd2, 32'h11);
    wr(3'd2, 32'h3FFF);
    bus(3'd3, 1'b0, 32'h0, 1'b1, 1'b0, 8'h0, d, lat);
    chk("stb_drop_data", d, 32'hA5A5A5A5);
    chk("stb_drop_latency", 32'(lat), 32'd3);
    rd_chk("rd_wrap_data", 3'd3, 32'h12345678);

    // FIFO fill past capacity, then drain.
    push_seq(17, 8'h00);
    rd_chk("fifo_ovf_status", 3'd4, 32'h00001007);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("fifo_pop%0d", i), 3'd5, 32'h100 + 32'(i));
    rd_chk("fifo_pop_empty", 3'd5, 32'h0);
    rd_chk("fifo_sticky_ovf", 3'd4, 32'h4);
    wr(3'd4, 32'h4);
    rd_chk("fifo_ovf_cleared", 3'd4, 32'h0);

    // Push and pop in the same cycle while full.
    push_seq(16, 8'h20);
    rd_chk("full_status", 3'd4, 32'h00001003);
    bus(3'd5, 1'b0, 32'h0, 1'b0, 1'b1, 8'hAA, d, lat);
    chk("full_pushpop_data", d, 32'h120);
    rd_chk("full_pushpop_status", 3'd4, 32'h00001003);
    push_seq(1, 8'hBB);
    rd_chk("full_drop_status", 3'd4, 32'h00001007);
    wr(3'd4, 32'hFFFFFFFB);
    rd_chk("w0_keeps_ovf", 3'd4, 32'h00001007);
    wr(3'd4, 32'h4);
    rd_chk("w1c_ovf", 3'd4, 32'h00001003);
    for (int i = 1; i < 16; i++) rd_chk($sformatf("drain%0d", i), 3'd5, 32'h120 + 32'(i));
    rd_chk("drain_pushed", 3'd5, 32'h1AA);
    rd_chk("drain_status", 3'd4, 32'h0);

    // Push and pop in the same cycle while empty.
    bus(3'd5, 1'b0, 32'h0, 1'b0, 1'b1, 8'h55, d, lat);
    chk("empty_pushpop_data", d, 32'h0);
    rd_chk("empty_pushpop_status", 3'd4, 32'h00000101);
    rd_chk("empty_pushpop_byte", 3'd5, 32'h155);

    // Reset in the middle of a RAM read.
    wr(3'd0, 32'h0);
    chk("cores_released", 32'(core_rst), 32'h0);
    push_seq(3, 8'h70);
    wb_adr = 3'd3; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_re_in_wait", 32'(ram_re), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_core_rst", 32'(core_rst), 32'h3);
    chk("mid_rst_ack_re", {30'b0, wb_ack, ram_re}, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    base = re_cnt;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    chk("mid_rst_no_ack", 32'(acks), 32'd0);
    chk("mid_rst_no_re", 32'(re_cnt - base), 32'd0);
    chk("mid_rst_outputs", {wb_dat_r[28:0], core_sel}, 32'h0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
    rd(3'd0, d, lat);
    chk("post_rst_latency", 32'(lat), 32'd1);
    chk("post_rst_reset_reg", d, 32'h3);
    rd_chk("post_rst_fifo_empty", 3'd4, 32'h0);

    // Randomized run against a queue model of the FIFO and the control registers.
    movf = 1'b0;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        k = $urandom_range(1, 6);
        for (int j = 0; j < int'(k); j++) begin
          v = 1'($urandom_range(0, 1));
          dbg_valid = v;
          dbg_data  = 8'($urandom);
          @(posedge clk); #1;
          if (v) begin
            if (mq.size() < 16) mq.push_back(dbg_data);
            else movf = 1'b1;
          end
        end
        dbg_valid = 1'b0;
      end else if (r <= 6) begin
        if (mq.size() > 0) begin
          exp_d = {23'b0, 1'b1, mq[0]};
          void'(mq.pop_front());
        end else begin
          exp_d = 32'h0;
        end
        rd_chk("rnd_dbg_data", 3'd5, exp_d);
      end else if (r == 7) begin
        exp_d = {16'b0, 8'(mq.size()), 5'b0, movf, mq.size() == 16, mq.size() != 0};
        rd_chk("rnd_dbg_status", 3'd4, exp_d);
      end else if (r == 8) begin
        wd = $urandom;
        wr(3'd4, wd);
        if (wd[2]) movf = 1'b0;
      end else begin
        wd = $urandom;
        wr(3'd0, wd);
        chk("rnd_core_rst", 32'(core_rst), 32'(wd[1:0]));
        rd_chk("rnd_reset_rd", 3'd0, 32'(wd[1:0]));
        wd = $urandom;
        wr(3'd1, wd);
        chk("rnd_core_sel", 32'(core_sel), 32'(wd[2:0]));
        rd_chk("rnd_sel_rd", 3'd1, 32'(wd[2:0]));
      end
    end
    exp_d = {16'b0, 8'(mq.size()), 5'b0, movf, mq.size() == 16, mq.size() != 0};
    rd_chk("rnd_final_status", 3'd4, exp_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
